// File: rtl/wimax_stream_checker.sv
// Self-check block for the WiMAX PHY chain: streams IN_VEC MSB-first into a stage under
// test and compares the returned serial stream against EXP_VEC over one or more frames.
module wimax_stream_checker #(
  parameter int unsigned          VEC_LEN = 96,
  parameter logic [VEC_LEN-1:0]   IN_VEC  = 96'hACBCD2114DAE1577C6DBF4C9,
  parameter logic [VEC_LEN-1:0]   EXP_VEC = 96'h558AC4A53A1724E163AC2BF9,
  parameter int unsigned          FRAMES  = 1,
  parameter int unsigned          ERR_W   = 8,
  parameter int unsigned          FRM_W   = 16,
  parameter int unsigned          IDX_W   = $clog2(VEC_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic             stim_data,
  output logic             stim_valid,
  input  logic             stim_ready,
  input  logic             dut_data,
  input  logic             dut_valid,
  output logic             dut_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [FRM_W-1:0] frame_cnt,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [FRM_W-1:0] first_err_frame
);

  localparam logic [IDX_W-1:0] LastIdx    = IDX_W'(VEC_LEN - 1);
  localparam logic [FRM_W-1:0] FramesW    = FRM_W'(FRAMES);
  localparam logic [ERR_W-1:0] ErrMax     = '1;
  localparam bit               Continuous = (FRAMES == 0);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] stim_idx_q, stim_idx_d;
  logic [FRM_W-1:0] stim_frm_q, stim_frm_d;
  logic [IDX_W-1:0] chk_idx_q, chk_idx_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0] first_idx_q, first_idx_d;
  logic [FRM_W-1:0] first_frm_q, first_frm_d;
  logic             first_seen_q, first_seen_d;
  logic             mismatch_q, mismatch_d;

  logic             stim_fire, chk_fire, miss, last_chk, clear_run;
  logic [FRM_W-1:0] frame_inc;

  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign pass       = done && (err_cnt_q == '0);
  assign stim_data  = IN_VEC[stim_idx_q];
  // In continuous mode the stimulus frame counter just wraps and never gates the stream.
  assign stim_valid = busy && (Continuous || (stim_frm_q < FramesW));
  assign dut_ready  = busy;

  assign mismatch        = mismatch_q;
  assign err_cnt         = err_cnt_q;
  assign frame_cnt       = frame_cnt_q;
  assign first_err_idx   = first_idx_q;
  assign first_err_frame = first_frm_q;

  assign stim_fire = stim_valid && stim_ready;
  assign chk_fire  = dut_valid && dut_ready;
  assign miss      = chk_fire && (dut_data != EXP_VEC[chk_idx_q]);
  assign last_chk  = (chk_idx_q == '0);
  assign frame_inc = frame_cnt_q + FRM_W'(1);

  always_comb begin
    state_d      = state_q;
    stim_idx_d   = stim_idx_q;
    stim_frm_d   = stim_frm_q;
    chk_idx_d    = chk_idx_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_idx_d  = first_idx_q;
    first_frm_d  = first_frm_q;
    first_seen_d = first_seen_q;
    mismatch_d   = 1'b0;
    clear_run    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          clear_run = 1'b1;
        end
      end
      StRun: begin
        if (stim_fire) begin
          stim_idx_d = (stim_idx_q == '0) ? LastIdx : stim_idx_q - IDX_W'(1);
          if (stim_idx_q == '0) stim_frm_d = stim_frm_q + FRM_W'(1);
        end
        if (chk_fire) begin
          chk_idx_d = last_chk ? LastIdx : chk_idx_q - IDX_W'(1);
          if (last_chk) frame_cnt_d = frame_inc;
        end
        if (miss) begin
          mismatch_d = 1'b1;
          err_cnt_d  = (err_cnt_q == ErrMax) ? err_cnt_q : err_cnt_q + ERR_W'(1);
          if (!first_seen_q) begin
            first_seen_d = 1'b1;
            first_idx_d  = chk_idx_q;
            first_frm_d  = frame_cnt_q;
          end
        end
        // stop takes priority; a start seen here is simply ignored.
        if (stop || (!Continuous && chk_fire && last_chk && (frame_inc == FramesW))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (start) begin
          state_d   = StRun;
          clear_run = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clear_run) begin
      stim_idx_d   = LastIdx;
      stim_frm_d   = '0;
      chk_idx_d    = LastIdx;
      frame_cnt_d  = '0;
      err_cnt_d    = '0;
      first_idx_d  = '0;
      first_frm_d  = '0;
      first_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      stim_idx_q   <= LastIdx;
      stim_frm_q   <= '0;
      chk_idx_q    <= LastIdx;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_frm_q  <= '0;
      first_seen_q <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stim_idx_q   <= stim_idx_d;
      stim_frm_q   <= stim_frm_d;
      chk_idx_q    <= chk_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_idx_q  <= first_idx_d;
      first_frm_q  <= first_frm_d;
      first_seen_q <= first_seen_d;
      mismatch_q   <= mismatch_d;
    end
  end

endmodule

// File: tb/tb_wimax_stream_checker.sv
// Scoreboard bench for wimax_stream_checker: three instances (FRAMES=1, FRAMES=2/ERR_W=7,
// FRAMES=0) driven by directed sequences; a negedge monitor pops expected events.
module tb_wimax_stream_checker;

  localparam logic [95:0] InVec  = 96'hACBCD2114DAE1577C6DBF4C9;
  localparam logic [95:0] ExpVec = 96'h558AC4A53A1724E163AC2BF9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, stop = 1'b0;
  logic stim_ready = 1'b1, dut_data = 1'b0, dut_valid = 1'b0;
  logic [95:0] in_v  = InVec;
  logic [95:0] exp_v = ExpVec;

  int checks = 0;
  int failures = 0;

  logic        a_sd, a_sv, a_dr, a_busy, a_done, a_pass, a_mm;
  logic [7:0]  a_err;
  logic [15:0] a_frm, a_ffrm;
  logic [6:0]  a_fidx;
  logic        b_sd, b_sv, b_dr, b_busy, b_done, b_pass, b_mm;
  logic [6:0]  b_err;
  logic [15:0] b_frm, b_ffrm;
  logic [6:0]  b_fidx;
  logic        c_sd, c_sv, c_dr, c_busy, c_done, c_pass, c_mm;
  logic [7:0]  c_err;
  logic [15:0] c_frm, c_ffrm;
  logic [6:0]  c_fidx;

  wimax_stream_checker u_a (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop),
    .stim_data(a_sd), .stim_valid(a_sv), .stim_ready(stim_ready),
    .dut_data(dut_data), .dut_valid(dut_valid), .dut_ready(a_dr),
    .busy(a_busy), .done(a_done), .pass(a_pass), .mismatch(a_mm),
    .err_cnt(a_err), .frame_cnt(a_frm), .first_err_idx(a_fidx), .first_err_frame(a_ffrm)
  );

  wimax_stream_checker #(.FRAMES(2), .ERR_W(7)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop),
    .stim_data(b_sd), .stim_valid(b_sv), .stim_ready(stim_ready),
    .dut_data(dut_data), .dut_valid(dut_valid), .dut_ready(b_dr),
    .busy(b_busy), .done(b_done), .pass(b_pass), .mismatch(b_mm),
    .err_cnt(b_err), .frame_cnt(b_frm), .first_err_idx(b_fidx), .first_err_frame(b_ffrm)
  );

  wimax_stream_checker #(.FRAMES(0)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .stop(stop),
    .stim_data(c_sd), .stim_valid(c_sv), .stim_ready(stim_ready),
    .dut_data(dut_data), .dut_valid(dut_valid), .dut_ready(c_dr),
    .busy(c_busy), .done(c_done), .pass(c_pass), .mismatch(c_mm),
    .err_cnt(c_err), .frame_cnt(c_frm), .first_err_idx(c_fidx), .first_err_frame(c_ffrm)
  );

  typedef struct {
    int err;
    int frm;
    int fidx;
    int ffrm;
    int pass;
  } status_t;

  status_t sta_q[$];
  status_t stb_q[$];
  status_t stc_q[$];
  logic    stim_q[$];
  int      mm_q[$];

  function automatic status_t mk(int e, int f, int i, int ff, int p);
    status_t s;
    s.err = e; s.frm = f; s.fidx = i; s.ffrm = ff; s.pass = p;
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_ev(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none at %0t", name, $time);
  endtask

  task automatic cmp_status(input string tag, input status_t e, input logic [63:0] err,
                            input logic [63:0] frm, input logic [63:0] fidx,
                            input logic [63:0] ffrm, input logic [63:0] pass);
    chk({tag, "_err_cnt"}, err, 64'(e.err));
    chk({tag, "_frame_cnt"}, frm, 64'(e.frm));
    chk({tag, "_first_err_idx"}, fidx, 64'(e.fidx));
    chk({tag, "_first_err_frame"}, ffrm, 64'(e.ffrm));
    chk({tag, "_pass"}, pass, 64'(e.pass));
  endtask

  // Monitor: consumes expected stimulus bits, mismatch pulses and end-of-run status.
  logic prev_stall = 1'b0, prev_data = 1'b0;
  logic a_done_p = 1'b0, b_done_p = 1'b0, c_done_p = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
      a_done_p   <= 1'b0;
      b_done_p   <= 1'b0;
      c_done_p   <= 1'b0;
    end else begin
      if (prev_stall && a_sv) chk("stim_hold", 64'(a_sd), 64'(prev_data));
      if (a_sv && stim_ready) begin
        if (stim_q.size() == 0) fail_ev("stim_extra_beat");
        else chk("stim_bit", 64'(a_sd), 64'(stim_q.pop_front()));
      end
      prev_stall <= a_sv && !stim_ready;
      prev_data  <= a_sd;
      if (a_mm) begin
        if (mm_q.size() == 0) fail_ev("mismatch_extra_pulse");
        else chk("mismatch_err_cnt", 64'(a_err), 64'(mm_q.pop_front()));
      end
      if (a_done && !a_done_p) begin
        if (sta_q.size() == 0) fail_ev("a_done_unexpected");
        else cmp_status("a", sta_q.pop_front(), 64'(a_err), 64'(a_frm), 64'(a_fidx),
                        64'(a_ffrm), 64'(a_pass));
      end
      if (b_done && !b_done_p) begin
        if (stb_q.size() == 0) fail_ev("b_done_unexpected");
        else cmp_status("b", stb_q.pop_front(), 64'(b_err), 64'(b_frm), 64'(b_fidx),
                        64'(b_ffrm), 64'(b_pass));
      end
      if (c_done && !c_done_p) begin
        if (stc_q.size() == 0) fail_ev("c_done_unexpected");
        else cmp_status("c", stc_q.pop_front(), 64'(c_err), 64'(c_frm), 64'(c_fidx),
                        64'(c_ffrm), 64'(c_pass));
      end
      a_done_p <= a_done;
      b_done_p <= b_done;
      c_done_p <= c_done;
    end
  end

  // Called just after an edge; returns just after the edge that sampled start.
  task automatic pulse_start(input int which);
    case (which)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic drive_beats(input int n, input int first_k, input int flip, input bit inv_all);
    for (int k = first_k; k < first_k + n; k++) begin
      int idx;
      idx       = 95 - (k % 96);
      dut_valid = 1'b1;
      dut_data  = exp_v[idx] ^ (inv_all || (idx == flip && k < 96));
      @(posedge clk); #1;
    end
    dut_valid = 1'b0;
  endtask

  task automatic push_stim_a();
    for (int k = 0; k < 96; k++) stim_q.push_back(in_v[95-k]);
  endtask

  task automatic run_a(input int flip);
    push_stim_a();
    if (flip < 0) sta_q.push_back(mk(0, 1, 0, 0, 1));
    else begin
      sta_q.push_back(mk(1, 1, flip, 0, 0));
      mm_q.push_back(1);
    end
    pulse_start(0);
    chk("busy_after_start", 64'(a_busy), 64'd1);
    chk("stim_valid_after_start", 64'(a_sv), 64'd1);
    drive_beats(95, 0, flip, 1'b0);
    chk("busy_before_last_beat", 64'(a_busy), 64'd1);
    drive_beats(1, 95, flip, 1'b0);
    chk("busy_after_last_beat", 64'(a_busy), 64'd0);
    chk("done_after_last_beat", 64'(a_done), 64'd1);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_busy"}, 64'(a_busy), 64'd0);
    chk({tag, "_done"}, 64'(a_done), 64'd0);
    chk({tag, "_pass"}, 64'(a_pass), 64'd0);
    chk({tag, "_mismatch"}, 64'(a_mm), 64'd0);
    chk({tag, "_stim_valid"}, 64'(a_sv), 64'd0);
    chk({tag, "_dut_ready"}, 64'(a_dr), 64'd0);
    chk({tag, "_stim_data"}, 64'(a_sd), 64'(in_v[95]));
    chk({tag, "_err_cnt"}, 64'(a_err), 64'd0);
    chk({tag, "_frame_cnt"}, 64'(a_frm), 64'd0);
    chk({tag, "_first_err_idx"}, 64'(a_fidx), 64'd0);
    chk({tag, "_first_err_frame"}, 64'(a_ffrm), 64'd0);
  endtask

  // Stage model with 5-cycle latency, random output gaps and a 1,0,0 stimulus stall pattern.
  task automatic run_latency();
    int  pipe_idx[$];
    int  pipe_rdy[$];
    int  cyc, s_cnt, c_cnt, dummy;
    bit  acc_s, acc_c;
    cyc = 0; s_cnt = 0; c_cnt = 0;
    push_stim_a();
    sta_q.push_back(mk(0, 1, 0, 0, 1));
    pulse_start(0);
    while (!a_done && cyc < 2000) begin
      stim_ready = (cyc % 3 == 0);
      if (pipe_idx.size() > 0 && pipe_rdy[0] <= cyc && $urandom_range(0, 3) != 0) begin
        dut_valid = 1'b1;
        dut_data  = exp_v[pipe_idx[0]];
      end else begin
        dut_valid = 1'b0;
      end
      @(negedge clk);
      acc_s = a_sv && stim_ready;
      acc_c = dut_valid && a_dr;
      @(posedge clk); #1;
      if (acc_s) begin
        pipe_idx.push_back(95 - s_cnt);
        pipe_rdy.push_back(cyc + 5);
        s_cnt++;
      end
      if (acc_c) begin
        dummy = pipe_idx.pop_front();
        dummy = pipe_rdy.pop_front();
        c_cnt++;
      end
      cyc++;
    end
    dut_valid  = 1'b0;
    stim_ready = 1'b1;
    chk("lat_done_within_budget", 64'(a_done), 64'd1);
    chk("lat_check_beats", 64'(c_cnt), 64'd96);
    chk("lat_stim_beats", 64'(s_cnt), 64'd96);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_a("rst");

    run_a(-1);
    run_a(10);
    run_latency();

    // Reset in the middle of a run drops everything in flight.
    push_stim_a();
    sta_q.push_back(mk(0, 1, 0, 0, 1));
    pulse_start(0);
    drive_beats(50, 0, -1, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stim_q.delete();
    sta_q.delete();
    check_reset_a("midrst");
    run_a(-1);

    // FRAMES=2, ERR_W=7, every returned bit inverted.
    stb_q.push_back(mk(127, 2, 95, 0, 0));
    pulse_start(1);
    drive_beats(192, 0, -1, 1'b1);
    chk("b_done", 64'(b_done), 64'd1);

    // FRAMES=0: three clean frames, then stop mid-frame.
    stc_q.push_back(mk(0, 3, 0, 0, 1));
    pulse_start(2);
    drive_beats(3 * 96 + 40, 0, -1, 1'b0);
    chk("c_busy_before_stop", 64'(c_busy), 64'd1);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("c_done_after_stop", 64'(c_done), 64'd1);
    chk("c_busy_after_stop", 64'(c_busy), 64'd0);
    pulse_start(2);
    chk("c_restart_busy", 64'(c_busy), 64'd1);
    chk("c_restart_done", 64'(c_done), 64'd0);
    chk("c_restart_frame_cnt", 64'(c_frm), 64'd0);
    chk("c_restart_stim_data", 64'(c_sd), 64'(in_v[95]));
    stc_q.push_back(mk(0, 0, 0, 0, 1));
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(posedge clk); #1;

    chk("stim_queue_drained", 64'(stim_q.size()), 64'd0);
    chk("mismatch_queue_drained", 64'(mm_q.size()), 64'd0);
    chk("a_status_queue_drained", 64'(sta_q.size()), 64'd0);
    chk("b_status_queue_drained", 64'(stb_q.size()), 64'd0);
    chk("c_status_queue_drained", 64'(stc_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
